// File: rtl/tfab_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tfab_pkg
//  Purpose  : Shared types and constants for the ternary frame sequencer.
//             Holds the trit encoding, the accepted opcodes, the exec-hint bit
//             positions, the sequencer state encoding and the PT-5 byte decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package tfab_pkg;

  // Two-bit trit encoding on the lane bus; 2'b11 is never produced
  typedef enum logic [1:0] {
    T_ZERO = 2'b00,
    T_POS  = 2'b01,
    T_NEG  = 2'b10
  } trit_t;

  localparam logic [7:0] OP_DOT   = 8'h01;
  localparam logic [7:0] OP_TGEMM = 8'h06;

  localparam int HINT_ZSKIP = 17;
  localparam int HINT_FNEG  = 18;
  localparam int HINT_BCAST = 19;

  // Largest legal PT-5 byte: 3^5 - 1
  localparam logic [7:0] PT5_MAX = 8'd242;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_ISSUE = 3'd4,
    S_DONE  = 3'd5
  } seq_state_t;

  // Returns {valid, trit4, trit3, trit2, trit1, trit0}; trit j = (v / 3^j) % 3.
  // Out-of-range bytes decode to all-zero trits with valid cleared.
  function automatic logic [10:0] pt5_decode(input logic [7:0] v);
    logic [7:0] rem;
    logic [9:0] trits;
    trit_t      t;
    trits = '0;
    rem   = v;
    for (int j = 0; j < 5; j++) begin
      case (rem % 8'd3)
        8'd0:    t = T_ZERO;
        8'd1:    t = T_POS;
        default: t = T_NEG;
      endcase
      trits[2*j +: 2] = t;
      rem = rem / 8'd3;
    end
    if (v > PT5_MAX) begin
      return 11'd0;
    end
    return {1'b1, trits};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tfab_pt5_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : tfab_pt5_unpack
//  Purpose  : Splits one SRAM word into per-lane trits. Byte b of the word
//             feeds lanes 5b..5b+4; any out-of-range byte raises invalid.
//  Revision : 1.0 - initial release
// ============================================================================
module tfab_pt5_unpack
  import tfab_pkg::*;
#(
  parameter int LANES = 15
) (
  input  logic [31:0]        word,
  output logic [2*LANES-1:0] trits,
  output logic               invalid
);

  localparam int NBYTES = (LANES + 4) / 5;

  logic [NBYTES-1:0] byte_bad;

  for (genvar b = 0; b < NBYTES; b++) begin : g_byte
    logic [10:0] dec;
    assign dec         = pt5_decode(word[8*b +: 8]);
    assign byte_bad[b] = ~dec[10];
    for (genvar j = 0; j < 5; j++) begin : g_trit
      if (5*b + j < LANES) begin : g_lane
        assign trits[2*(5*b+j) +: 2] = dec[2*j +: 2];
      end
    end
  end

  // Bytes above the lane range carry no data
  if (NBYTES < 4) begin : g_spare
    logic unused_bytes;
    assign unused_bytes = ^word[31:8*NBYTES];
  end

  assign invalid = |byte_bad;

endmodule
`default_nettype wire

// File: rtl/ternary_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ternary_frame_sequencer
//  Purpose  : Runs one DOT/TGEMM frame: latches the frame registers on start,
//             reads weight/input SRAM at base+k*stride, unpacks PT-5 bytes to
//             per-lane trits and issues them to the engine under backpressure.
//  Options  : TFAB_SEQ_PERF_EN - enables the perf_cycles/perf_skips counters;
//             when undefined both outputs are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module ternary_frame_sequencer
  import tfab_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int LANES    = 15,
  parameter int DEPTH_W  = 16,
  parameter int SRAM_LAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_start,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [DEPTH_W-1:0]  cfg_depth,
  input  logic [ADDR_W-1:0]   cfg_stride,
  input  logic [4:0]          cfg_lane_count,
  input  logic [31:0]         cfg_hints,
  output logic                w_rd_en,
  output logic [ADDR_W-1:0]   w_rd_addr,
  input  logic [31:0]         w_rd_data,
  output logic                i_rd_en,
  output logic [ADDR_W-1:0]   i_rd_addr,
  input  logic [31:0]         i_rd_data,
  output logic [2*LANES-1:0]  lane_w,
  output logic [2*LANES-1:0]  lane_i,
  output logic [LANES-1:0]    lane_mask,
  output logic                lane_valid,
  output logic                lane_neg_en,
  output logic                acc_clear,
  input  logic                eng_ready,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         perf_cycles,
  output logic [31:0]         perf_skips
);

  localparam int                WCNT_W    = (SRAM_LAT > 1) ? $clog2(SRAM_LAT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(SRAM_LAT - 1);

  seq_state_t         state, state_n;
  logic [ADDR_W-1:0]  addr, stride;
  logic [DEPTH_W-1:0] depth, step;
  logic               skip_en, bcast_en, op_ok;
  logic [31:0]        w_word, i_word;
  logic [WCNT_W-1:0]  wait_cnt;
  logic [LANES-1:0]   mask_in;
  logic [2*LANES-1:0] w_raw, i_raw;
  logic               w_bad, i_bad;
  logic               rd_en, step_adv, last_step, skip_now, start_ok;
  logic               unused_hints;

  assign unused_hints = ^{cfg_hints[31:20], cfg_hints[16:8]};

  assign start_ok  = (state == S_IDLE) && cfg_start;
  assign last_step = ((step + DEPTH_W'(1)) == depth);
  assign busy      = (state != S_IDLE);

  assign w_rd_en   = rd_en;
  assign i_rd_en   = rd_en;
  assign w_rd_addr = addr;
  assign i_rd_addr = addr;

  // Lane n is active when n < lane_count; counts above LANES enable every lane
  for (genvar n = 0; n < LANES; n++) begin : g_mask
    assign mask_in[n] = (32'(n) < {27'd0, cfg_lane_count});
  end

  tfab_pt5_unpack #(.LANES(LANES)) u_w_unpack (
    .word    (w_word),
    .trits   (w_raw),
    .invalid (w_bad)
  );

  tfab_pt5_unpack #(.LANES(LANES)) u_i_unpack (
    .word    (i_word),
    .trits   (i_raw),
    .invalid (i_bad)
  );

  // Broadcast replicates lane 0's weight; masked lanes are forced to zero
  for (genvar n = 0; n < LANES; n++) begin : g_lane_out
    assign lane_w[2*n +: 2] = lane_mask[n] ? (bcast_en ? w_raw[1:0] : w_raw[2*n +: 2]) : 2'b00;
    assign lane_i[2*n +: 2] = lane_mask[n] ? i_raw[2*n +: 2] : 2'b00;
  end

  assign skip_now = skip_en && (lane_w == '0);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next-state and per-state strobes
  always_comb begin
    state_n    = state;
    rd_en      = 1'b0;
    lane_valid = 1'b0;
    acc_clear  = 1'b0;
    done       = 1'b0;
    step_adv   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_start) state_n = S_START;
      end
      S_START: begin
        acc_clear = 1'b1;
        state_n   = (!op_ok || depth == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        if (skip_now) begin
          step_adv = 1'b1;
          state_n  = last_step ? S_DONE : S_FETCH;
        end else begin
          lane_valid = 1'b1;
          if (eng_ready) begin
            step_adv = 1'b1;
            state_n  = last_step ? S_DONE : S_FETCH;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Frame registers latch on an accepted start; address advances per completed step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr        <= '0;
      stride      <= '0;
      depth       <= '0;
      lane_mask   <= '0;
      skip_en     <= 1'b0;
      bcast_en    <= 1'b0;
      lane_neg_en <= 1'b0;
      op_ok       <= 1'b0;
    end else if (start_ok) begin
      addr        <= cfg_base;
      stride      <= cfg_stride;
      depth       <= cfg_depth;
      lane_mask   <= mask_in;
      skip_en     <= cfg_hints[HINT_ZSKIP];
      bcast_en    <= cfg_hints[HINT_BCAST];
      lane_neg_en <= cfg_hints[HINT_FNEG];
      op_ok       <= (cfg_hints[7:0] == OP_DOT) || (cfg_hints[7:0] == OP_TGEMM);
    end else if (step_adv) begin
      addr        <= addr + stride;
    end
  end

  // Step counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      step <= '0;
    else if (start_ok) step <= '0;
    else if (step_adv) step <= step + DEPTH_W'(1);
  end

  // Read-latency counter; SRAM data is captured on the last WAIT cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      w_word   <= '0;
      i_word   <= '0;
    end else if (state == S_FETCH) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      if (wait_cnt == WAIT_LAST) begin
        w_word <= w_rd_data;
        i_word <= i_rd_data;
      end else begin
        wait_cnt <= wait_cnt + WCNT_W'(1);
      end
    end
  end

  // Sticky error: bad opcode at START, or an undecodable byte while issuing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             err <= 1'b0;
    else if (state == S_START)                err <= !op_ok;
    else if (state == S_ISSUE && (w_bad || i_bad)) err <= 1'b1;
  end

`ifdef TFAB_SEQ_PERF_EN
  logic skip_step;
  assign skip_step = (state == S_ISSUE) && skip_now;

  // Perf counters: START counts as the first busy cycle, frozen while idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles <= '0;
      perf_skips  <= '0;
    end else if (state == S_START) begin
      perf_cycles <= 32'd1;
      perf_skips  <= '0;
    end else if (busy) begin
      perf_cycles <= perf_cycles + 32'd1;
      if (skip_step) perf_skips <= perf_skips + 32'd1;
    end
  end
`else
  assign perf_cycles = '0;
  assign perf_skips  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ternary_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ternary_frame_sequencer
//  Purpose  : Directed self-checking bench for ternary_frame_sequencer with a
//             one-cycle-latency SRAM model indexed by address[1:0].
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ternary_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_start;
  logic [31:0] cfg_base;
  logic [15:0] cfg_depth;
  logic [31:0] cfg_stride;
  logic [4:0]  cfg_lane_count;
  logic [31:0] cfg_hints;
  logic        w_rd_en, i_rd_en;
  logic [31:0] w_rd_addr, i_rd_addr;
  logic [31:0] w_rd_data = '0;
  logic [31:0] i_rd_data = '0;
  logic [29:0] lane_w, lane_i;
  logic [14:0] lane_mask;
  logic        lane_valid, lane_neg_en, acc_clear, eng_ready;
  logic        busy, done, err;
  logic [31:0] perf_cycles, perf_skips;

  int n_cmp  = 0;
  int n_fail = 0;
  int rd_cnt = 0, valid_cnt = 0, done_cnt = 0;
  int d0, r0, v0;

  logic [31:0] w_tab [4];
  logic [31:0] i_tab [4];

  always #5 clk = ~clk;

  ternary_frame_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_start      (cfg_start),
    .cfg_base       (cfg_base),
    .cfg_depth      (cfg_depth),
    .cfg_stride     (cfg_stride),
    .cfg_lane_count (cfg_lane_count),
    .cfg_hints      (cfg_hints),
    .w_rd_en        (w_rd_en),
    .w_rd_addr      (w_rd_addr),
    .w_rd_data      (w_rd_data),
    .i_rd_en        (i_rd_en),
    .i_rd_addr      (i_rd_addr),
    .i_rd_data      (i_rd_data),
    .lane_w         (lane_w),
    .lane_i         (lane_i),
    .lane_mask      (lane_mask),
    .lane_valid     (lane_valid),
    .lane_neg_en    (lane_neg_en),
    .acc_clear      (acc_clear),
    .eng_ready      (eng_ready),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .perf_cycles    (perf_cycles),
    .perf_skips     (perf_skips)
  );

  // SRAM model: one-cycle read latency
  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= w_tab[w_rd_addr[1:0]];
    if (i_rd_en) i_rd_data <= i_tab[i_rd_addr[1:0]];
  end

  // Event counters
  always @(posedge clk) begin
    if (w_rd_en)    rd_cnt    <= rd_cnt + 1;
    if (lane_valid) valid_cnt <= valid_cnt + 1;
    if (done)       done_cnt  <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] w, input logic [31:0] i);
    for (int k = 0; k < 4; k++) begin
      w_tab[k] = w;
      i_tab[k] = i;
    end
  endtask

  task automatic start_frame(input logic [31:0] base, input logic [15:0] depth,
                             input logic [31:0] stride, input logic [4:0] lc,
                             input logic [31:0] hints);
    cfg_base       = base;
    cfg_depth      = depth;
    cfg_stride     = stride;
    cfg_lane_count = lc;
    cfg_hints      = hints;
    cfg_start      = 1'b1;
    @(negedge clk);
    cfg_start      = 1'b0;
    chk("start acc_clear/busy", {acc_clear, busy}, 2'b11);
  endtask

  task automatic wait_rd(input string tag);
    int n;
    n = 0;
    while (!w_rd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " rd_en"}, {w_rd_en, i_rd_en}, 2'b11);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!lane_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " lane_valid"}, lane_valid, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done"}, done, 1'b1);
    @(negedge clk);
    chk({tag, " done 1-cycle/idle"}, {done, busy}, 2'b00);
  endtask

  // One issued step: check address, data, optional hold with eng_ready low, then accept
  task automatic issue_step(input string tag, input logic [31:0] exp_addr,
                            input logic [29:0] exp_w, input logic [29:0] exp_i,
                            input int hold, input bit poke_start);
    wait_rd(tag);
    chk({tag, " addr"}, {w_rd_addr, i_rd_addr}, {exp_addr, exp_addr});
    wait_valid(tag);
    chk({tag, " lane_w"}, lane_w, exp_w);
    chk({tag, " lane_i"}, lane_i, exp_i);
    for (int h = 0; h < hold; h++) begin
      cfg_start = poke_start && (h == 0);
      @(negedge clk);
      cfg_start = 1'b0;
      chk({tag, " held"}, {lane_valid, lane_w, lane_i}, {1'b1, exp_w, exp_i});
    end
    eng_ready = 1'b1;
    @(negedge clk);
    eng_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; cfg_start = 1'b0; cfg_base = '0; cfg_depth = '0; cfg_stride = '0;
    cfg_lane_count = '0; cfg_hints = '0; eng_ready = 1'b0;
    fill(32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("reset outputs", {busy, done, err, lane_valid, acc_clear, lane_neg_en, w_rd_en, i_rd_en},
        8'h00);
    chk("reset lanes", {lane_w, lane_i, lane_mask}, 75'd0);
    chk("reset perf", {perf_cycles, perf_skips}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: basic DOT step, zero-skip enabled but weights nonzero
    fill(32'h00C4C4C4, 32'h00797979);
    d0 = done_cnt;
    start_frame(32'h0, 16'd1, 32'h1, 5'd15, 32'h0006_0001);
    issue_step("t1", 32'h0, {3{10'h249}}, {3{10'h155}}, 0, 1'b0);
    chk("t1 mask/neg", {lane_mask, lane_neg_en}, {15'h7FFF, 1'b1});
    wait_done("t1");
    repeat (2) @(negedge clk);
    chk("t1 done once", done_cnt - d0, 1);
    chk("t1 err", err, 1'b0);

    // 2: broadcast of lane 0 weight (-1), TGEMM opcode
    fill(32'h0000_0002, 32'h00797979);
    start_frame(32'h0, 16'd1, 32'h1, 5'd15, 32'h000E_0006);
    issue_step("t2", 32'h0, {15{2'b10}}, {3{10'h155}}, 0, 1'b0);
    chk("t2 neg_en", lane_neg_en, 1'b1);
    wait_done("t2");

    // 3: lane_count 2 masks lanes 2..14
    fill(32'h00797979, 32'h00797979);
    start_frame(32'h0, 16'd1, 32'h1, 5'd2, 32'h0000_0001);
    issue_step("t3", 32'h0, 30'h5, 30'h5, 0, 1'b0);
    chk("t3 mask/neg", {lane_mask, lane_neg_en}, {15'h0003, 1'b0});
    wait_done("t3");

    // 4: address wrap, backpressure hold, start while busy ignored, lane_count clamp
    w_tab[0] = 32'd1; w_tab[1] = 32'd2; w_tab[2] = 32'd3; w_tab[3] = 32'd4;
    for (int k = 0; k < 4; k++) i_tab[k] = 32'h0;
    d0 = done_cnt;
    start_frame(32'hFFFF_FFFE, 16'd4, 32'h1, 5'd31, 32'h0000_0001);
    cfg_base  = 32'h0000_0100;
    cfg_depth = 16'd1;
    issue_step("t4 s0", 32'hFFFF_FFFE, 30'h4, 30'h0, 0, 1'b0);
    chk("t4 mask clamp", lane_mask, 15'h7FFF);
    issue_step("t4 s1", 32'hFFFF_FFFF, 30'h5, 30'h0, 5, 1'b1);
    issue_step("t4 s2", 32'h0000_0000, 30'h1, 30'h0, 0, 1'b0);
    issue_step("t4 s3", 32'h0000_0001, 30'h2, 30'h0, 0, 1'b0);
    wait_done("t4");
    chk("t4 done once", done_cnt - d0, 1);

    // 5: zero-skip on every step
    fill(32'h0, 32'h00797979);
    r0 = rd_cnt; v0 = valid_cnt;
    start_frame(32'h0, 16'd3, 32'h1, 5'd15, 32'h0002_0001);
    wait_done("t5");
    chk("t5 no lane_valid", valid_cnt - v0, 0);
    chk("t5 reads", rd_cnt - r0, 3);
`ifdef TFAB_SEQ_PERF_EN
    chk("t5 perf_skips", perf_skips, 32'd3);
`else
    chk("t5 perf_skips", perf_skips, 32'd0);
`endif

    // 6a: undecodable weight byte
    fill(32'h0000_00F3, 32'h00797979);
    start_frame(32'h0, 16'd1, 32'h1, 5'd15, 32'h0000_0001);
    issue_step("t6a", 32'h0, 30'h0, {3{10'h155}}, 0, 1'b0);
    wait_done("t6a");
    chk("t6a err", err, 1'b1);

    // depth 0: next accepted start clears err, no reads
    r0 = rd_cnt;
    start_frame(32'h0, 16'd0, 32'h1, 5'd15, 32'h0000_0001);
    @(negedge clk);
    chk("d0 done/err", {done, err}, 2'b10);
    chk("d0 reads", rd_cnt - r0, 0);
    @(negedge clk);

    // 6b: bad opcode
    r0 = rd_cnt; v0 = valid_cnt;
    start_frame(32'h0, 16'd2, 32'h1, 5'd15, 32'h0000_0007);
    wait_done("t6b");
    chk("t6b err", err, 1'b1);
    chk("t6b no activity", {rd_cnt - r0, valid_cnt - v0}, 64'd0);

    // 6c: reset while issuing aborts without done
    fill(32'h00797979, 32'h00797979);
    start_frame(32'h0, 16'd2, 32'h1, 5'd15, 32'h0000_0001);
    wait_rd("t6c");
    wait_valid("t6c");
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    chk("t6c async reset", {busy, lane_valid, w_rd_en, err, done, lane_mask}, 20'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6c no done", {done_cnt - d0, 31'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
